// File: rtl/chunked_subtractor_pkg.sv
// Shared types and elaboration helpers for the chunked subtractor.
package chunked_subtractor_pkg;

    // Control states of the chunk sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the operand width splits into whole chunks.
    function automatic bit chunk_legal(input int unsigned width, input int unsigned chunk);
        return (width >= 1) && (chunk >= 1) && ((width % chunk) == 0);
    endfunction

    // Index width for a counter over n positions, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_subtractor_if.sv
// Operand/result handshake bundle for the chunked subtractor.
interface chunked_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/chunked_subtractor_sub_chunk.sv
// Combinational CHUNK-bit ripple subtractor built from full-subtractor cells.
module sub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             bin_i,
    output logic [CHUNK-1:0] d_o,
    output logic             bout_o,
    output logic             msb_bin_o
);

    // br[i] is the borrow into bit i; br[CHUNK] leaves the chunk.
    logic [CHUNK:0] br;

    assign br[0] = bin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        assign d_o[i]  = a_i[i] ^ b_i[i] ^ br[i];
        assign br[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
    end

    assign bout_o    = br[CHUNK];
    // Borrow into the top bit feeds the signed-overflow rule.
    assign msb_bin_o = br[CHUNK-1];

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle a - b - bin, CHUNK bits per clock from the LSB chunk upward,
// with valid/ready handshakes and borrow/overflow/zero flags.
module chunked_subtractor
    import chunked_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    chunked_subtractor_if.slave  bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = clog2_min1(NCHUNK);

    // Reject a chunk size that does not tile the operand.
    if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("chunked_subtractor: CHUNK must divide WIDTH exactly");
    end

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              out_valid_q, out_valid_d;

    logic [CHUNK-1:0]  a_ch;
    logic [CHUNK-1:0]  b_ch;
    logic [CHUNK-1:0]  d_ch;
    logic              ch_bout;
    logic              ch_msb_bin;

    // Select the operand slices addressed by the current chunk index.
    always_comb begin : p_chunk_mux
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // One chunk subtractor shared across all chunk positions.
    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .a_i       (a_ch),
        .b_i       (b_ch),
        .bin_i     (borrow_q),
        .d_o       (d_ch),
        .bout_o    (ch_bout),
        .msb_bin_o (ch_msb_bin)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
    always_comb begin : p_next
        state_d     = state_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        diff_d[k*CHUNK +: CHUNK] = d_ch;
                    end
                end
                borrow_d = ch_bout;
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    bout_d      = ch_bout;
                    ovf_d       = ch_msb_bin ^ ch_bout;
                    zero_d      = (diff_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is forced low while reset is held.
    assign bus.in_ready  = ~rst & (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench: directed corner cases plus randomized operations
// compared against an arithmetic model of a - b - bin.
module tb_chunked_subtractor;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned TMO    = 20;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    chunked_subtractor_if #(.WIDTH(WIDTH)) bus ();

    chunked_subtractor #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Count one comparison and report it if it does not match.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: unsigned and signed arithmetic at wider precision.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bo, output logic ov,
                                  output logic z);
        logic [32:0] full;
        longint      sr;
        full = {1'b0, a} - {1'b0, b} - 33'(bin);
        d    = full[31:0];
        bo   = full[32];
        sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ov   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        z    = (d == 32'd0);
    endfunction

    // Issue one operation, check latency and flags, then drain it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input int unsigned stall, input bit early_ready);
        logic [31:0] ed;
        logic        eb, eo, ez;
        int unsigned lat;
        model(a, b, bin, ed, eb, eo, ez);

        lat = 0;
        while (!bus.in_ready && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);

        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        @(posedge clk);
        @(negedge clk);
        // Operand changes after acceptance must have no effect.
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.bin       = 1'($urandom_range(0, 1));
        bus.out_ready = early_ready;

        lat = 0;
        while (!bus.out_valid && lat < TMO) begin
            check_eq("in_ready_busy", 64'(bus.in_ready), 64'd0);
            if (!early_ready) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(NCHUNK));

        if (!early_ready) bus.out_ready = 1'b0;
        for (int s = 0; s <= int'(stall); s++) begin
            check_eq("out_valid", 64'(bus.out_valid), 64'd1);
            check_eq("diff", 64'(bus.diff), 64'(ed));
            check_eq("bout", 64'(bus.bout), 64'(eb));
            check_eq("ovf", 64'(bus.ovf), 64'(eo));
            check_eq("zero", 64'(bus.zero), 64'(ez));
            check_eq("in_ready_done", 64'(bus.in_ready), 64'd0);
            if (early_ready) break;
            if (s < int'(stall)) begin
                bus.in_valid = 1'b1;
                bus.a        = $urandom;
                bus.b        = $urandom;
                @(negedge clk);
            end
        end

        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("out_valid_drop", 64'(bus.out_valid), 64'd0);
        check_eq("in_ready_after", 64'(bus.in_ready), 64'd1);
    endtask

    logic [31:0] dir_a   [6] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h0000_0100, 32'h0000_0000};
    logic [31:0] dir_b   [6] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                                 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_0000};
    logic        dir_bin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_diff", 64'(bus.diff), 64'd0);
        check_eq("rst_flags", 64'({bus.bout, bus.ovf, bus.zero}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed corner cases.
        for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i], dir_bin[i], 0, 1'b0);

        // Backpressure held for five cycles in DONE.
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 5, 1'b0);

        // out_ready held high gives a one-cycle DONE.
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 0, 1'b1);

        // Reset after two RUN cycles aborts the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h0101_0101;
        bus.bin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_run_valid", 64'(bus.out_valid), 64'd0);
        rst = 1'b1;
        #1;
        check_eq("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("abort_diff", 64'(bus.diff), 64'd0);
        check_eq("abort_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("release_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("release_out_valid", 64'(bus.out_valid), 64'd0);
        run_op(32'd10, 32'd3, 1'b0, 0, 1'b0);

        // Randomized operations with random stalls and ready modes.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
